dm_be: RTL and testbench



---
 rtl/dm_be.sv | 165 ++++++++++++++++
 tb/tb_dm_be.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/dm_be.sv
// dm_be: byte-addressable data memory with sized, extended loads,
// misalignment detection and a post-reset zero-fill sequencer.
module dm_be #(
    parameter int ADDR_W         = 12,
    parameter bit CLEAR_ON_RESET = 1'b1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req,
    input  logic              we,
    input  logic [ADDR_W-1:0] addr,
    input  logic [1:0]        size,
    input  logic              uext,
    input  logic [31:0]       din,
    output logic              ready,
    output logic              rvalid,
    output logic [31:0]       dout,
    output logic              err
);

    localparam int IDX_W = ADDR_W - 2;
    localparam int WORDS = 1 << IDX_W;

    typedef enum logic {
        S_CLEAR,
        S_RUN
    } state_e;

    state_e             state_q;
    logic [IDX_W-1:0]   clr_idx_q;
    logic [IDX_W-1:0]   clr_idx_d;
    logic               ready_q;
    logic               rvalid_q;
    logic               err_q;
    logic [31:0]        dout_q;
    logic [31:0]        mem_q [WORDS];

    logic [IDX_W-1:0]   idx;
    logic [1:0]         off;
    logic               acc;
    logic               bad;
    logic               st_en;
    logic               ld_en;
    logic               clr_we;
    logic [3:0]         be;
    logic [31:0]        wdata;
    logic [31:0]        rd_word;
    logic [7:0]         rd_byte;
    logic [15:0]        rd_half;
    logic [31:0]        ld_data;

    assign idx       = addr[ADDR_W-1:2];
    assign off       = addr[1:0];
    assign acc       = req & ready_q;
    assign st_en     = acc & we & ~bad;
    assign ld_en     = acc & ~we & ~bad;
    assign clr_we    = CLEAR_ON_RESET && (state_q == S_CLEAR);
    assign clr_idx_d = clr_idx_q + 1'b1;

    always_comb begin
        bad = 1'b1;
        unique case (size)
            2'b00:   bad = 1'b0;
            2'b01:   bad = off[0];
            2'b10:   bad = |off;
            default: bad = 1'b1;
        endcase
    end

    // Store data is replicated so each enabled lane finds its bits in place.
    always_comb begin
        be    = 4'b0000;
        wdata = din;
        unique case (size)
            2'b00: begin
                be    = 4'b0001 << off;
                wdata = {4{din[7:0]}};
            end
            2'b01: begin
                be    = off[1] ? 4'b1100 : 4'b0011;
                wdata = {2{din[15:0]}};
            end
            2'b10:   be = 4'b1111;
            default: be = 4'b0000;
        endcase
    end

    assign rd_word = mem_q[idx];

    always_comb begin
        rd_byte = rd_word[7:0];
        unique case (off)
            2'b00:   rd_byte = rd_word[7:0];
            2'b01:   rd_byte = rd_word[15:8];
            2'b10:   rd_byte = rd_word[23:16];
            default: rd_byte = rd_word[31:24];
        endcase
    end

    assign rd_half = off[1] ? rd_word[31:16] : rd_word[15:0];

    always_comb begin
        ld_data = rd_word;
        unique case (size)
            2'b00: ld_data = uext ? {24'b0, rd_byte}
                                  : {{24{rd_byte[7]}}, rd_byte};
            2'b01: ld_data = uext ? {16'b0, rd_half}
                                  : {{16{rd_half[15]}}, rd_half};
            default: ld_data = rd_word;
        endcase
    end

    // The array itself carries no reset; zero-fill is done by the sequencer.
    always_ff @(posedge clk) begin
        if (clr_we) begin
            mem_q[clr_idx_q] <= '0;
        end else if (st_en) begin
            for (int k = 0; k < 4; k++) begin
                if (be[k]) begin
                    mem_q[idx][8*k +: 8] <= wdata[8*k +: 8];
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= CLEAR_ON_RESET ? S_CLEAR : S_RUN;
            clr_idx_q <= '0;
            ready_q   <= 1'b0;
            rvalid_q  <= 1'b0;
            err_q     <= 1'b0;
            dout_q    <= '0;
        end else begin
            rvalid_q <= 1'b0;
            err_q    <= 1'b0;
            unique case (state_q)
                S_CLEAR: begin
                    ready_q   <= 1'b0;
                    clr_idx_q <= clr_idx_d;
                    if (&clr_idx_q) begin
                        state_q   <= S_RUN;
                        ready_q   <= 1'b1;
                        clr_idx_q <= '0;
                    end
                end
                default: begin
                    ready_q <= 1'b1;
                    if (acc && bad) begin
                        err_q <= 1'b1;
                    end else if (ld_en) begin
                        rvalid_q <= 1'b1;
                        dout_q   <= ld_data;
                    end
                end
            endcase
        end
    end

    assign ready  = ready_q;
    assign rvalid = rvalid_q;
    assign err    = err_q;
    assign dout   = dout_q;

endmodule

// File: tb/tb_dm_be.sv
// tb_dm_be: scoreboard bench for dm_be (cleared and uncleared builds,
// 16-word array).
module tb_dm_be;

    logic        clk;
    logic        rst_c;
    logic        rst_u;
    logic        req;
    logic        we;
    logic [5:0]  addr;
    logic [1:0]  size;
    logic        uext;
    logic [31:0] din;

    logic        c_ready, c_rvalid, c_err;
    logic [31:0] c_dout;
    logic        u_ready, u_rvalid, u_err;
    logic [31:0] u_dout;

    dm_be #(.ADDR_W(6), .CLEAR_ON_RESET(1'b1)) u_c (
        .clk(clk), .rst_n(rst_c), .req(req), .we(we),
        .addr(addr), .size(size), .uext(uext), .din(din),
        .ready(c_ready), .rvalid(c_rvalid), .dout(c_dout), .err(c_err)
    );

    dm_be #(.ADDR_W(6), .CLEAR_ON_RESET(1'b0)) u_n (
        .clk(clk), .rst_n(rst_u), .req(req), .we(we),
        .addr(addr), .size(size), .uext(uext), .din(din),
        .ready(u_ready), .rvalid(u_rvalid), .dout(u_dout), .err(u_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        bit          rv;
        bit          er;
        logic [31:0] d;
        string       tag;
    } exp_t;

    exp_t        sbq[$];
    logic [31:0] mdl [16];
    logic [31:0] last_dout;
    int          n_chk;
    int          n_pass;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_chk++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %h want %h", tag, obs, exp);
    endtask

    function automatic bit is_bad(input logic [5:0] a, input logic [1:0] s);
        if (s == 2'd3) return 1'b1;
        if (s == 2'd1) return a[0];
        if (s == 2'd2) return a[1:0] != 2'd0;
        return 1'b0;
    endfunction

    function automatic logic [31:0] mdl_ld(input logic [5:0] a,
                                           input logic [1:0] s,
                                           input logic u);
        logic [31:0] w;
        logic [31:0] sh;
        w  = mdl[a[5:2]];
        sh = w >> (8 * a[1:0]);
        if (s == 2'd0) return u ? {24'h0, sh[7:0]} : {{24{sh[7]}}, sh[7:0]};
        if (s == 2'd1) return u ? {16'h0, sh[15:0]} : {{16{sh[15]}}, sh[15:0]};
        return w;
    endfunction

    task automatic mdl_st(input logic [5:0] a, input logic [1:0] s,
                          input logic [31:0] d);
        int o;
        o = int'(a[1:0]);
        if (s == 2'd0) mdl[a[5:2]][8*o +: 8] = d[7:0];
        else if (s == 2'd1) mdl[a[5:2]][16*(o/2) +: 16] = d[15:0];
        else mdl[a[5:2]] = d;
    endtask

    task automatic mdl_clear();
        for (int i = 0; i < 16; i++) mdl[i] = '0;
        last_dout = '0;
    endtask

    // Called at a falling edge; drives one request and checks its response
    // at the following falling edge. use_x forces a literal expectation.
    task automatic step(input string tag, input bit r, input bit w,
                        input logic [5:0] a, input logic [1:0] s,
                        input bit u, input logic [31:0] d,
                        input bit use_x, input logic [31:0] xv);
        exp_t e;
        req = r; we = w; addr = a; size = s; uext = u; din = d;
        e.tag = tag; e.rv = 1'b0; e.er = 1'b0;
        if (r && is_bad(a, s)) begin
            e.er = 1'b1;
        end else if (r && w) begin
            mdl_st(a, s, d);
        end else if (r) begin
            e.rv = 1'b1;
            last_dout = use_x ? xv : mdl_ld(a, s, u);
        end
        e.d = last_dout;
        sbq.push_back(e);
        @(posedge clk);
        @(negedge clk);
        e = sbq.pop_front();
        chk({e.tag, ".rvalid"}, {31'b0, c_rvalid}, {31'b0, e.rv});
        chk({e.tag, ".err"}, {31'b0, c_err}, {31'b0, e.er});
        chk({e.tag, ".dout"}, c_dout, e.d);
    endtask

    task automatic idle();
        req = 1'b0; we = 1'b0; addr = '0; size = 2'd2; uext = 1'b0; din = '0;
    endtask

    task automatic wait_ready(input string tag);
        int n;
        n = 0;
        do begin
            @(posedge clk);
            @(negedge clk);
            n++;
        end while (!c_ready && n < 64);
        chk(tag, n, 16);
    endtask

    initial begin
        n_chk = 0;
        n_pass = 0;
        idle();
        mdl_clear();
        rst_c = 1'b1;
        rst_u = 1'b1;
        #1;
        rst_c = 1'b0;
        rst_u = 1'b0;
        #1;
        chk("rst.ready", {31'b0, c_ready}, 32'd0);
        chk("rst.rvalid", {31'b0, c_rvalid}, 32'd0);
        chk("rst.err", {31'b0, c_err}, 32'd0);
        chk("rst.dout", c_dout, 32'd0);

        @(negedge clk);
        rst_c = 1'b1;
        wait_ready("clr1.len");

        for (int i = 0; i < 16; i++)
            step("junk.st", 1, 1, 6'(i * 4), 2'd2, 0,
                 32'hA5A5A5A5 ^ (32'h01010101 * i), 0, 0);
        step("junk.ld4", 1, 0, 6'h04, 2'd2, 0, 0, 0, 0);
        step("junk.ld3c", 1, 0, 6'h3C, 2'd2, 0, 0, 0, 0);

        // Reset while a load response is on the outputs.
        step("pre_rst.ld", 1, 0, 6'h08, 2'd2, 0, 0, 0, 0);
        idle();
        rst_c = 1'b0;
        #1;
        chk("run_rst.rvalid", {31'b0, c_rvalid}, 32'd0);
        chk("run_rst.dout", c_dout, 32'd0);
        chk("run_rst.ready", {31'b0, c_ready}, 32'd0);
        mdl_clear();
        @(negedge clk);
        rst_c = 1'b1;
        wait_ready("clr2.len");
        for (int i = 0; i < 16; i++)
            step("clr.ld", 1, 0, 6'(i * 4), 2'd2, 0, 0, 1, 32'h0);

        step("st.w10", 1, 1, 6'h10, 2'd2, 0, 32'h11223344, 0, 0);
        step("st.b11", 1, 1, 6'h11, 2'd0, 0, 32'h000000AA, 0, 0);
        step("st.h12", 1, 1, 6'h12, 2'd1, 0, 32'h00008001, 0, 0);
        step("ld.w10", 1, 0, 6'h10, 2'd2, 0, 0, 1, 32'h8001AA44);
        step("ld.b11s", 1, 0, 6'h11, 2'd0, 0, 0, 1, 32'hFFFFFFAA);
        step("ld.h12u", 1, 0, 6'h12, 2'd1, 1, 0, 1, 32'h00008001);
        step("ld.b13u", 1, 0, 6'h13, 2'd0, 1, 0, 0, 0);
        step("ld.h10s", 1, 0, 6'h10, 2'd1, 0, 0, 0, 0);
        step("ld.h12s", 1, 0, 6'h12, 2'd1, 0, 0, 0, 0);
        step("ld.b10s", 1, 0, 6'h10, 2'd0, 0, 0, 0, 0);

        step("mis.h13", 1, 0, 6'h13, 2'd1, 0, 0, 0, 0);
        step("mis.w12", 1, 1, 6'h12, 2'd2, 0, 32'hFFFFFFFF, 0, 0);
        step("mis.s3", 1, 0, 6'h10, 2'd3, 0, 0, 0, 0);
        step("mis.after", 1, 0, 6'h10, 2'd2, 0, 0, 1, 32'h8001AA44);
        step("idle", 0, 0, 6'h0, 2'd2, 0, 0, 0, 0);

        step("coh.pre", 1, 1, 6'h24, 2'd2, 0, 32'hCAFEF00D, 0, 0);
        step("coh.st", 1, 1, 6'h20, 2'd2, 0, 32'hDEADBEEF, 0, 0);
        step("coh.ld20", 1, 0, 6'h20, 2'd2, 0, 0, 1, 32'hDEADBEEF);
        step("coh.ld24", 1, 0, 6'h24, 2'd2, 0, 0, 1, 32'hCAFEF00D);
        step("coh.tail", 0, 0, 6'h0, 2'd2, 0, 0, 0, 0);

        // Reset part-way through the clear walk.
        rst_c = 1'b0;
        @(negedge clk);
        rst_c = 1'b1;
        repeat (7) @(posedge clk);
        @(negedge clk);
        chk("mid.ready_lo", {31'b0, c_ready}, 32'd0);
        rst_c = 1'b0;
        #1;
        chk("mid.ready", {31'b0, c_ready}, 32'd0);
        chk("mid.dout", c_dout, 32'd0);
        mdl_clear();
        @(negedge clk);
        rst_c = 1'b1;
        wait_ready("clr3.len");
        step("clr3.ld20", 1, 0, 6'h20, 2'd2, 0, 0, 1, 32'h0);
        idle();

        // Build without clear: request during reset must be dropped.
        req = 1'b1; we = 1'b0; addr = 6'h00; size = 2'd2;
        @(negedge clk);
        chk("nc.rst_ready", {31'b0, u_ready}, 32'd0);
        chk("nc.rst_rvalid", {31'b0, u_rvalid}, 32'd0);
        rst_u = 1'b1;
        @(negedge clk);
        chk("nc.ready1", {31'b0, u_ready}, 32'd1);
        chk("nc.rvalid0", {31'b0, u_rvalid}, 32'd0);
        req = 1'b0;
        @(negedge clk);
        chk("nc.rvalid1", {31'b0, u_rvalid}, 32'd0);
        req = 1'b1; we = 1'b1; addr = 6'h08; size = 2'd2; din = 32'h12345678;
        @(negedge clk);
        we = 1'b0;
        @(negedge clk);
        chk("nc.ld.rvalid", {31'b0, u_rvalid}, 32'd1);
        chk("nc.ld.dout", u_dout, 32'h12345678);
        idle();
        @(negedge clk);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
